// File: rtl/button_pkg.sv
// Shared types and default timing constants for the debounced pushbutton bank.
// The defaults assume a 50 MHz system clock.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HOLD,
    LOCK
  } btn_state_t;

  localparam int DEF_DEBOUNCE_TICKS = 500_000;     // 10 ms
  localparam int DEF_HOLD_TICKS     = 25_000_000;  // 0.5 s
  localparam int DEF_REPEAT_TICKS   = 10_000_000;  // 5 Hz

  // One counter width serves both the debounce counter and the hold/repeat timer.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: polarity normalisation, 2-flop synchroniser,
// time-based debounce and the press/click/hold/repeat event FSM.
module button_channel
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  input  logic en,
  output logic pressed,
  output logic press,
  output logic click,
  output logic release_evt,
  output logic held,
  output logic repeat_tick
);

  localparam int TW = timer_width(DEBOUNCE_TICKS, HOLD_TICKS, REPEAT_TICKS);
  localparam logic [TW-1:0] DB_LAST   = TW'(DEBOUNCE_TICKS - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_TICKS - 1);

  logic          key_norm;
  logic          sync_q1;
  logic          sync_q2;
  logic          deb_q;
  logic [TW-1:0] db_cnt;
  logic [TW-1:0] timer;
  btn_state_t    state;

  // Internally 1 always means "pressed", whatever the pin polarity.
  assign key_norm = ACTIVE_LOW ? ~key_raw : key_raw;
  assign pressed  = deb_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values and block ordering cannot change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      deb_q   <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync_q1 <= key_norm;
      sync_q2 <= sync_q1;
      if (sync_q2 == deb_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        deb_q  <= sync_q2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      press       <= 1'b0;
      click       <= 1'b0;
      release_evt <= 1'b0;
      held        <= 1'b0;
      repeat_tick <= 1'b0;
    end else begin
      press       <= 1'b0;
      click       <= 1'b0;
      release_evt <= 1'b0;
      repeat_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (deb_q) begin
            if (en) begin
              press <= 1'b1;
              timer <= '0;
              state <= PRESS;
            end else begin
              state <= LOCK;
            end
          end
        end
        PRESS: begin
          if (!en) begin
            state <= LOCK;
          end else if (!deb_q) begin
            click       <= 1'b1;
            release_evt <= 1'b1;
            state       <= IDLE;
          end else if (timer == HOLD_LAST) begin
            held        <= 1'b1;
            repeat_tick <= REPEAT_EN;
            timer       <= '0;
            state       <= HOLD;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD: begin
          if (!en) begin
            held  <= 1'b0;
            state <= LOCK;
          end else if (!deb_q) begin
            release_evt <= 1'b1;
            held        <= 1'b0;
            state       <= IDLE;
          end else if (timer == REP_LAST) begin
            repeat_tick <= REPEAT_EN;
            timer       <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOCK: begin
          // A key held across a disable must be let go before it can fire again.
          if (!deb_q) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_bank.sv
// N-channel debounced pushbutton front end: independent channels plus
// combined any/multi-press flags for the control FSM.
module button_bank
  import button_pkg::*;
#(
  parameter int N_BUTTONS      = 4,
  parameter bit ACTIVE_LOW     = 1'b1,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int HOLD_TICKS     = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] key_raw,
  input  logic                 en,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] click,
  output logic [N_BUTTONS-1:0] release_evt,  // "release" is a reserved word
  output logic [N_BUTTONS-1:0] held,
  output logic [N_BUTTONS-1:0] repeat_tick,
  output logic                 any_pressed,
  output logic                 multi_pressed
);

  if (DEBOUNCE_TICKS < 1 || HOLD_TICKS < 2 || REPEAT_TICKS < 1) begin : g_bad_params
    $error("button_bank: need DEBOUNCE_TICKS>=1, HOLD_TICKS>=2, REPEAT_TICKS>=1");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW    (ACTIVE_LOW),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .HOLD_TICKS    (HOLD_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS),
      .REPEAT_EN     (REPEAT_EN)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_raw    (key_raw[i]),
      .en         (en),
      .pressed    (pressed[i]),
      .press      (press[i]),
      .click      (click[i]),
      .release_evt(release_evt[i]),
      .held       (held[i]),
      .repeat_tick(repeat_tick[i])
    );
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any_pressed   = |pressed;
  assign multi_pressed = |(pressed & (pressed - 1'b1));

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank with short tick counts (debounce 4, hold 20, repeat 8).
module tb_button_bank;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_raw = '1;
  logic         en = 1'b1;
  logic [N-1:0] pressed, press, click, release_evt, held, repeat_tick;
  logic         any_pressed, multi_pressed;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  button_bank #(
    .N_BUTTONS     (N),
    .ACTIVE_LOW    (1'b1),
    .DEBOUNCE_TICKS(4),
    .HOLD_TICKS    (20),
    .REPEAT_TICKS  (8),
    .REPEAT_EN     (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_raw      (key_raw),
    .en           (en),
    .pressed      (pressed),
    .press        (press),
    .click        (click),
    .release_evt  (release_evt),
    .held         (held),
    .repeat_tick  (repeat_tick),
    .any_pressed  (any_pressed),
    .multi_pressed(multi_pressed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] all_outs();
    return {pressed, press, click, release_evt, held, repeat_tick, any_pressed, multi_pressed};
  endfunction

  // Ticks until press[ch] is seen; returns 0 if it never comes within 20 ticks.
  task automatic wait_press(input int ch, output int waited);
    waited = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (press[ch] === 1'b1) begin
        waited = t;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_raw = '1;
    en = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (all_outs() !== 26'd0) begin
      n_errors++;
      $display("FAIL reset_hold: outs=%h expected 0", all_outs());
    end
    rst_n = 1'b1;
    key_raw[0] = 1'b0;
    repeat (8) tick();
    n_checks++;
    if (pressed[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_setup: pressed[0]=%b expected 1", pressed[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 26'd0) begin
      n_errors++;
      $display("FAIL reset_async: outs=%h expected 0", all_outs());
    end
    key_raw = '1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (all_outs() !== 26'd0) begin
      n_errors++;
      $display("FAIL reset_release: outs=%h expected 0", all_outs());
    end
    repeat (3) tick();
  endtask

  task automatic test_debounce();
    int g_pressed = 0, g_press = 0, g_click = 0;
    int first_pressed = -1, press_at = -1, press_cnt = 0;
    key_raw[0] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 3) key_raw[0] = 1'b1;
      if (pressed[0]) g_pressed++;
      if (press[0]) g_press++;
      if (click[0]) g_click++;
    end
    n_checks++;
    if (g_pressed !== 0) begin
      n_errors++;
      $display("FAIL glitch_pressed: cycles=%0d expected 0", g_pressed);
    end
    n_checks++;
    if (g_press !== 0) begin
      n_errors++;
      $display("FAIL glitch_press: pulses=%0d expected 0", g_press);
    end
    n_checks++;
    if (g_click !== 0) begin
      n_errors++;
      $display("FAIL glitch_click: pulses=%0d expected 0", g_click);
    end
    key_raw[0] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (pressed[0] && first_pressed < 0) first_pressed = t;
      if (press[0]) begin
        press_cnt++;
        press_at = t;
      end
    end
    n_checks++;
    if (first_pressed !== 6) begin
      n_errors++;
      $display("FAIL pressed_latency: cycle=%0d expected 6", first_pressed);
    end
    n_checks++;
    if (press_at !== 7) begin
      n_errors++;
      $display("FAIL press_latency: cycle=%0d expected 7", press_at);
    end
    n_checks++;
    if (press_cnt !== 1) begin
      n_errors++;
      $display("FAIL press_count: pulses=%0d expected 1", press_cnt);
    end
    key_raw[0] = 1'b1;
    repeat (15) tick();
  endtask

  task automatic test_click();
    int waited, held_seen = 0, press_cnt = 0;
    int click_cnt = 0, rel_cnt = 0, click_at = -1, rel_at = -1;
    key_raw[1] = 1'b0;
    wait_press(1, waited);
    n_checks++;
    if (waited !== 7) begin
      n_errors++;
      $display("FAIL click_press: latency=%0d expected 7", waited);
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (held[1]) held_seen++;
      if (press[1]) press_cnt++;
    end
    key_raw[1] = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (held[1]) held_seen++;
      if (press[1]) press_cnt++;
      if (click[1]) begin
        click_cnt++;
        click_at = t;
      end
      if (release_evt[1]) begin
        rel_cnt++;
        rel_at = t;
      end
    end
    n_checks++;
    if (press_cnt !== 0) begin
      n_errors++;
      $display("FAIL click_extra_press: pulses=%0d expected 0", press_cnt);
    end
    n_checks++;
    if (click_cnt !== 1) begin
      n_errors++;
      $display("FAIL click_count: pulses=%0d expected 1", click_cnt);
    end
    n_checks++;
    if (rel_cnt !== 1) begin
      n_errors++;
      $display("FAIL click_release_count: pulses=%0d expected 1", rel_cnt);
    end
    n_checks++;
    if (click_at !== 7 || rel_at !== 7) begin
      n_errors++;
      $display("FAIL click_timing: click=%0d release=%0d expected 7 and 7", click_at, rel_at);
    end
    n_checks++;
    if (held_seen !== 0) begin
      n_errors++;
      $display("FAIL click_held: cycles=%0d expected 0", held_seen);
    end
  endtask

  task automatic test_hold_repeat();
    int waited, held_rise = -1, rep_cnt = 0;
    int rep_at[8];
    int rel_at = -1, click_cnt = 0, held_at_rel = -1;
    key_raw[2] = 1'b0;
    wait_press(2, waited);
    n_checks++;
    if (waited !== 7) begin
      n_errors++;
      $display("FAIL hold_press: latency=%0d expected 7", waited);
    end
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (held[2] && held_rise < 0) held_rise = t;
      if (repeat_tick[2]) begin
        if (rep_cnt < 8) rep_at[rep_cnt] = t;
        rep_cnt++;
      end
    end
    n_checks++;
    if (held_rise !== 20) begin
      n_errors++;
      $display("FAIL hold_rise: cycle=%0d expected 20", held_rise);
    end
    n_checks++;
    if (rep_cnt !== 4) begin
      n_errors++;
      $display("FAIL repeat_count: pulses=%0d expected 4", rep_cnt);
    end
    if (rep_cnt >= 3) begin
      n_checks++;
      if (rep_at[0] !== 20 || rep_at[1] !== 28 || rep_at[2] !== 36) begin
        n_errors++;
        $display("FAIL repeat_timing: at %0d,%0d,%0d expected 20,28,36",
                 rep_at[0], rep_at[1], rep_at[2]);
      end
    end
    key_raw[2] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (click[2]) click_cnt++;
      if (release_evt[2] && rel_at < 0) begin
        rel_at = t;
        held_at_rel = int'(held[2]);
      end
    end
    n_checks++;
    if (rel_at !== 7) begin
      n_errors++;
      $display("FAIL hold_release: cycle=%0d expected 7", rel_at);
    end
    n_checks++;
    if (click_cnt !== 0) begin
      n_errors++;
      $display("FAIL hold_click: pulses=%0d expected 0", click_cnt);
    end
    n_checks++;
    if (held_at_rel !== 0) begin
      n_errors++;
      $display("FAIL hold_drop: held=%0d expected 0", held_at_rel);
    end
  endtask

  task automatic test_multi();
    int p0 = -1, p3 = -1, multi_at = -1, any_at = -1;
    key_raw[0] = 1'b0;
    key_raw[3] = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (press[0] && p0 < 0) p0 = t;
      if (press[3] && p3 < 0) p3 = t;
      if (press[0] && press[3] && multi_at < 0) begin
        multi_at = int'(multi_pressed);
        any_at   = int'(any_pressed);
      end
    end
    n_checks++;
    if (p0 !== 7 || p3 !== 7) begin
      n_errors++;
      $display("FAIL multi_press: ch0=%0d ch3=%0d expected 7 and 7", p0, p3);
    end
    n_checks++;
    if (multi_at !== 1) begin
      n_errors++;
      $display("FAIL multi_flag: multi=%0d expected 1", multi_at);
    end
    n_checks++;
    if (any_at !== 1) begin
      n_errors++;
      $display("FAIL multi_any: any=%0d expected 1", any_at);
    end
    key_raw[0] = 1'b1;
    key_raw[3] = 1'b1;
    repeat (12) tick();
    n_checks++;
    if ({any_pressed, multi_pressed} !== 2'b00) begin
      n_errors++;
      $display("FAIL multi_idle: any=%b multi=%b expected 0 0", any_pressed, multi_pressed);
    end
  endtask

  task automatic test_enable_lock();
    int ev = 0, waited;
    en = 1'b0;
    key_raw[1] = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 10) en = 1'b1;
      if (press[1] | click[1] | release_evt[1] | held[1] | repeat_tick[1]) ev++;
    end
    n_checks++;
    if (pressed[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL lock_level: pressed[1]=%b expected 1", pressed[1]);
    end
    key_raw[1] = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (press[1] | click[1] | release_evt[1] | held[1] | repeat_tick[1]) ev++;
    end
    n_checks++;
    if (ev !== 0) begin
      n_errors++;
      $display("FAIL lock_events: cycles=%0d expected 0", ev);
    end
    key_raw[1] = 1'b0;
    wait_press(1, waited);
    n_checks++;
    if (waited !== 7) begin
      n_errors++;
      $display("FAIL lock_repress: latency=%0d expected 7", waited);
    end
    key_raw[1] = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_click();
    test_hold_repeat();
    test_multi();
    test_enable_lock();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
